// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline.
// Handles load-use interlocks, taken-branch flushes, data-memory wait states
// with a timeout that halts the pipeline, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_RegDst,
    input  logic        EX_BranchTaken,
    input  logic        MEM_MemAccess,
    input  logic        Mem_Ack,
    output logic        Mem_Req,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        ID_EX_Write,
    output logic        EX_MEM_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Bubble,
    output logic        MEM_WB_Bubble,
    output logic        Mem_Err,
    output logic [15:0] StallCycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic mem_stall;
    logic load_use;

    // Hazard detection: outstanding memory access without ack, and load-use match
    always_comb begin
        mem_stall = MEM_MemAccess & ~Mem_Ack;
        load_use  = EX_MemRead && (EX_RegDst != 5'd0) &&
                    ((EX_RegDst == ID_Rs) || (ID_UsesRt && (EX_RegDst == ID_Rt)));
    end

    // Pipeline control outputs; priority is reset, halt, memory freeze, branch, load-use
    always_comb begin
        Mem_Req       = MEM_MemAccess;
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        EX_MEM_Write  = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Bubble  = 1'b0;
        MEM_WB_Bubble = 1'b0;
        if (!Reset) begin
            Mem_Req       = 1'b0;
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Write  = 1'b0;
            IF_ID_Flush   = 1'b1;
            ID_EX_Bubble  = 1'b1;
            MEM_WB_Bubble = 1'b1;
        end else if (state_q == HALT) begin
            Mem_Req       = 1'b0;
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Write  = 1'b0;
        end else if (mem_stall) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Write  = 1'b0;
            MEM_WB_Bubble = 1'b1;
        end else if (EX_BranchTaken) begin
            IF_ID_Flush   = 1'b1;
            ID_EX_Bubble  = 1'b1;
        end else if (load_use) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Bubble  = 1'b1;
        end
    end

    // Next-state logic for the wait/timeout FSM and the stall counter
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 4'd1;
                end
            end
            MEM_WAIT: begin
                // Leaving on !mem_stall covers an ack, and also a dropped access
                // (an ack with no access pending is meaningless).
                if (!mem_stall) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == MAX_WAIT_L) begin
                    state_d    = HALT;
                    mem_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (!PC_Write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Mem_Err     = mem_err_q;
    assign StallCycles = stall_cnt_q;

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter: MAX_WAIT, default 8, number of MEM_WAIT cycles without ack before timeout (range 1..15).
REQ-002 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-003 Reset  in  1  synchronous, active-low reset; sampled only on posedge Clk.
REQ-004 ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
REQ-005 ID_UsesRt  in  1  ID instruction reads Rt.
REQ-006 EX_MemRead  in  1  load in EX; EX_RegDst  in  5  its destination register.
REQ-007 EX_BranchTaken  in  1  branch/jump in EX resolved taken.
REQ-008 MEM_MemAccess  in  1  load or store in MEM; Mem_Ack  in  1  data memory completion.
REQ-009 Mem_Req  out  1  data memory request.
REQ-010 PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write  out  1 each  stage register enables.
REQ-011 IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble  out  1 each  insert NOP (zero control) into that register.
REQ-012 Mem_Err  out  1  sticky memory timeout flag; StallCycles  out  16  stall-cycle count.

Function
REQ-013 States: RUN, MEM_WAIT, HALT; 4-bit WaitCnt.
REQ-014 MemStall = MEM_MemAccess & ~Mem_Ack, evaluated combinationally, in RUN and MEM_WAIT.
REQ-015 Mem_Req = MEM_MemAccess in RUN and MEM_WAIT; 0 in HALT.
REQ-016 MemStall: all four enables 0, MEM_WB_Bubble 1, IF_ID_Flush 0, ID_EX_Bubble 0 (freeze has top priority).
REQ-017 Branch flush (no MemStall, EX_BranchTaken=1): IF_ID_Flush 1, ID_EX_Bubble 1, all enables 1; overrides load-use.
REQ-018 Load-use (no MemStall, no branch): EX_MemRead & EX_RegDst!=0 & (EX_RegDst==ID_Rs | (ID_UsesRt & EX_RegDst==ID_Rt)) -> PC_Write 0, IF_ID_Write 0, ID_EX_Bubble 1, ID_EX_Write 1, EX_MEM_Write 1.
REQ-019 No hazard: all enables 1, all flush/bubble outputs 0.
REQ-020 RUN -> MEM_WAIT when MemStall; WaitCnt <= 1.
REQ-021 MEM_WAIT: Mem_Ack=1 -> RUN, WaitCnt <= 0; else WaitCnt increments.
REQ-022 MEM_WAIT with WaitCnt==MAX_WAIT and Mem_Ack=0 -> HALT, Mem_Err <= 1.
REQ-023 Ack on the timeout cycle wins: -> RUN, no error.
REQ-024 HALT: all enables 0, all bubble/flush outputs 0, Mem_Req 0; exit only by reset.
REQ-025 StallCycles +1 on every posedge (outside reset) where PC_Write=0, HALT included; saturates at 16'hFFFF.
REQ-026 Load-use stall lasts exactly one cycle per load: the load advances to MEM and the hazard clears.
REQ-027 Mem_Ack outside a MemAccess cycle is ignored.

Reset
REQ-028 Reset=0 at posedge: state RUN, WaitCnt 0, Mem_Err 0, StallCycles 0.
REQ-029 While Reset=0: all enables 0, Mem_Req 0, IF_ID_Flush 1, ID_EX_Bubble 1, MEM_WB_Bubble 1.
REQ-030 Reset asserted in MEM_WAIT or HALT aborts the wait; the first cycle after release is RUN with counters cleared.

Verification
REQ-031 Load-use: EX_MemRead=1, EX_RegDst=8, ID_Rs=8 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, StallCycles=1; next cycle no stall.
REQ-032 $zero and Rt filtering: EX_RegDst=0, ID_Rs=0 -> no stall; EX_RegDst=9, ID_Rt=9, ID_UsesRt=0 -> no stall.
REQ-033 Branch with load-use: EX_BranchTaken=1 plus a load-use match -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1.
REQ-034 Memory wait: MEM_MemAccess=1, Mem_Ack after 3 cycles -> enables 0 and MEM_WB_Bubble=1 for 3 cycles, RUN on the ack cycle, StallCycles=3.
REQ-035 Timeout: MAX_WAIT=8, no ack -> HALT after the 8th wait cycle, Mem_Err=1, outputs frozen; Reset=0 for one cycle -> RUN, Mem_Err=0, StallCycles=0.
REQ-036 Saturation: stall held beyond 65535 cycles (HALT) -> StallCycles remains 16'hFFFF.
